// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and the control word,
// detects load-use hazards, injects bubbles, supports hold/flush and counts bubbles/flushes.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [10:0]      id_cu_out,
  input  logic             id_is_jal,
  input  logic             id_uses_rt,
  input  logic [DW-1:0]    id_pc4,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             ex_valid,
  output logic [10:0]      ex_cu_out,
  output logic             ex_is_jal,
  output logic [DW-1:0]    ex_pc4,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_wreg,
  output logic [4:0]       ex_shamt,
  output logic             lu_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [4:0] wreg_next;

  // Only instructions that actually write a register get a non-zero destination,
  // so the hazard and forwarding logic can treat $0 as "no destination".
  always_comb begin
    wreg_next = 5'd0;
    if (id_valid && id_cu_out[9]) begin
      if (id_is_jal)         wreg_next = 5'd31;
      else if (id_cu_out[10]) wreg_next = id_rd;
      else                    wreg_next = id_rt;
    end
  end

  assign lu_stall = ex_valid & ex_cu_out[7] & (ex_wreg != 5'd0) & id_valid &
                    ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_cu_out  <= '0;
      ex_is_jal  <= 1'b0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_wreg    <= '0;
      ex_shamt   <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush_i) begin
      ex_valid  <= 1'b0;
      ex_cu_out <= '0;
      ex_is_jal <= 1'b0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end else if (!hold_i) begin
      if (lu_stall) begin
        // Data fields are left as-is; ex_valid=0 makes them irrelevant.
        ex_valid  <= 1'b0;
        ex_cu_out <= '0;
        ex_is_jal <= 1'b0;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
      end else begin
        ex_valid   <= id_valid;
        ex_cu_out  <= id_valid ? id_cu_out : 11'd0;
        ex_is_jal  <= id_is_jal;
        ex_pc4     <= id_pc4;
        ex_rs_data <= id_rs_data;
        ex_rt_data <= id_rt_data;
        ex_imm     <= id_imm;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_wreg    <= wreg_next;
        ex_shamt   <= id_shamt;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the ID/EX rules.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = '1;

  localparam logic [10:0] CU_LW   = 11'h382;
  localparam logic [10:0] CU_ADD  = 11'h602;
  localparam logic [10:0] CU_ADDI = 11'h202;
  localparam logic [10:0] CU_SW   = 11'h042;
  localparam logic [10:0] CU_JAL  = 11'h210;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_is_jal, id_uses_rt, hold_i, flush_i;
  logic [10:0] id_cu_out;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt;
  logic ex_valid, ex_is_jal, lu_stall;
  logic [10:0] ex_cu_out;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_wreg, ex_shamt;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int asserts = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_cu_out(id_cu_out),
    .id_is_jal(id_is_jal), .id_uses_rt(id_uses_rt), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .hold_i(hold_i), .flush_i(flush_i), .ex_valid(ex_valid), .ex_cu_out(ex_cu_out),
    .ex_is_jal(ex_is_jal), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wreg(ex_wreg), .ex_shamt(ex_shamt), .lu_stall(lu_stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] cu, input logic jal,
                       input logic urt, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    id_valid = v; id_cu_out = cu; id_is_jal = jal; id_uses_rt = urt;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_pc4 = 32'h100 + {27'd0, rd}; id_rs_data = 32'hA000_0000 | rs;
    id_rt_data = 32'hB000_0000 | rt; id_imm = 32'h0000_0040; id_shamt = 5'd3;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    hold_i = 0; flush_i = 0;
    drive(1'b0, 11'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b0;
    #2;
    asserts++;
    if ({ex_valid, ex_cu_out, ex_is_jal, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
         ex_rs, ex_rt, ex_wreg, ex_shamt, lu_stall, bubble_cnt, flush_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b cu=%h wreg=%0d bcnt=%0d fcnt=%0d, want all 0",
               ex_valid, ex_cu_out, ex_wreg, bubble_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, CU_LW, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    asserts++;
    if (ex_wreg !== 5'd2 || ex_cu_out !== CU_LW) begin
      fails++; $display("FAIL lw_in_ex: got wreg=%0d cu=%h, want 2 %h", ex_wreg, ex_cu_out, CU_LW);
    end
    drive(1'b1, CU_ADD, 1'b0, 1'b1, 5'd2, 5'd4, 5'd3);
    asserts++;
    if (lu_stall !== 1'b1) begin
      fails++; $display("FAIL lu_stall_rs: got %b want 1", lu_stall);
    end
    tick();
    asserts++;
    if (ex_valid !== 1'b0 || ex_cu_out !== 11'd0 || bubble_cnt !== 4'd1 || lu_stall !== 1'b0) begin
      fails++;
      $display("FAIL bubble: got valid=%b cu=%h bcnt=%0d stall=%b, want 0 0 1 0",
               ex_valid, ex_cu_out, bubble_cnt, lu_stall);
    end
    tick();
    asserts++;
    if (ex_valid !== 1'b1 || ex_cu_out !== CU_ADD || ex_wreg !== 5'd3 || bubble_cnt !== 4'd1) begin
      fails++;
      $display("FAIL add_after_bubble: got valid=%b cu=%h wreg=%0d bcnt=%0d, want 1 %h 3 1",
               ex_valid, ex_cu_out, ex_wreg, bubble_cnt, CU_ADD);
    end
  endtask

  task automatic test_rs_only();
    drive(1'b1, CU_LW, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, CU_ADDI, 1'b0, 1'b0, 5'd7, 5'd2, 5'd0);
    asserts++;
    if (lu_stall !== 1'b0) begin
      fails++; $display("FAIL rt_ignored: got %b want 0", lu_stall);
    end
    drive(1'b1, CU_ADDI, 1'b0, 1'b0, 5'd2, 5'd5, 5'd0);
    asserts++;
    if (lu_stall !== 1'b1) begin
      fails++; $display("FAIL rs_match: got %b want 1", lu_stall);
    end
    tick();
    asserts++;
    if (bubble_cnt !== 4'd2) begin
      fails++; $display("FAIL bubble_cnt2: got %0d want 2", bubble_cnt);
    end
    drive(1'b1, CU_LW, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
    tick();
    drive(1'b1, CU_ADD, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6);
    asserts++;
    if (lu_stall !== 1'b0) begin
      fails++; $display("FAIL lw_r0: got %b want 0", lu_stall);
    end
    tick();
  endtask

  task automatic test_flush_hold();
    drive(1'b1, CU_ADD, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10);
    flush_i = 1; hold_i = 1;
    tick();
    asserts++;
    if (ex_valid !== 1'b0 || ex_cu_out !== 11'd0 || flush_cnt !== 4'd1) begin
      fails++; $display("FAIL flush_over_hold: got valid=%b cu=%h fcnt=%0d, want 0 0 1",
                        ex_valid, ex_cu_out, flush_cnt);
    end
    flush_i = 0; hold_i = 0;
    tick();
    hold_i = 1;
    drive(1'b1, CU_SW, 1'b0, 1'b1, 5'd11, 5'd12, 5'd13);
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (ex_valid !== 1'b1 || ex_cu_out !== CU_ADD || ex_wreg !== 5'd10 ||
          ex_rs_data !== 32'hA000_0008 || flush_cnt !== 4'd1 || bubble_cnt !== 4'd2) begin
        fails++;
        $display("FAIL hold_frozen[%0d]: got valid=%b cu=%h wreg=%0d rsd=%h, want 1 %h 10 a0000008",
                 i, ex_valid, ex_cu_out, ex_wreg, ex_rs_data, CU_ADD);
      end
    end
    hold_i = 0;
    tick();
  endtask

  task automatic test_dest();
    drive(1'b1, CU_JAL, 1'b1, 1'b0, 5'd0, 5'd3, 5'd7);
    tick();
    asserts++;
    if (ex_wreg !== 5'd31 || ex_is_jal !== 1'b1) begin
      fails++; $display("FAIL jal_dest: got wreg=%0d jal=%b want 31 1", ex_wreg, ex_is_jal);
    end
    drive(1'b1, CU_ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd9);
    tick();
    asserts++;
    if (ex_wreg !== 5'd9 || ex_is_jal !== 1'b0) begin
      fails++; $display("FAIL rtype_dest: got wreg=%0d jal=%b want 9 0", ex_wreg, ex_is_jal);
    end
    drive(1'b1, CU_ADDI, 1'b0, 1'b0, 5'd1, 5'd4, 5'd9);
    tick();
    asserts++;
    if (ex_wreg !== 5'd4) begin
      fails++; $display("FAIL itype_dest: got %0d want 4", ex_wreg);
    end
    drive(1'b1, CU_SW, 1'b0, 1'b1, 5'd1, 5'd6, 5'd9);
    tick();
    asserts++;
    if (ex_wreg !== 5'd0) begin
      fails++; $display("FAIL sw_dest: got %0d want 0", ex_wreg);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, CU_LW, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      drive(1'b1, CU_ADD, 1'b0, 1'b1, 5'd2, 5'd4, 5'd3);
      tick();
    end
    asserts++;
    if (bubble_cnt !== SAT) begin
      fails++; $display("FAIL bubble_sat: got %h want %h", bubble_cnt, SAT);
    end
    flush_i = 1;
    for (int i = 0; i < 16; i++) tick();
    flush_i = 0;
    asserts++;
    if (flush_cnt !== SAT) begin
      fails++; $display("FAIL flush_sat: got %h want %h", flush_cnt, SAT);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, CU_ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({ex_valid, ex_cu_out, ex_wreg, ex_rs_data, bubble_cnt, flush_cnt} !== '0) begin
      fails++; $display("FAIL midcycle_reset: got valid=%b cu=%h wreg=%0d bcnt=%0d fcnt=%0d, want 0",
                        ex_valid, ex_cu_out, ex_wreg, bubble_cnt, flush_cnt);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    bit valid; bit [10:0] cu; bit jal;
    bit [DW-1:0] pc4, rsd, rtd, imm;
    bit [4:0] rs, rt, wreg, shamt;
    int bcnt, fcnt;
  } ex_model_t;

  task automatic test_random();
    ex_model_t m;
    bit exp_stall;
    int cmax;
    int mism;
    cmax = (1 << CNT_W) - 1;
    hold_i = 0; flush_i = 0;
    drive(1'b0, 11'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    apply_reset();
    m = '{default: 0};
    mism = 0;
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom % 4) != 0;
      id_cu_out = 11'($urandom);
      if ($urandom % 2 == 0) id_cu_out[7] = 1'b1;
      id_is_jal = id_valid && ($urandom % 8 == 0);
      id_uses_rt = 1'($urandom);
      id_rs = 5'($urandom % 4); id_rt = 5'($urandom % 4); id_rd = 5'($urandom % 4);
      id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom);
      hold_i = ($urandom % 6) == 0;
      flush_i = ($urandom % 8) == 0;
      #1;
      exp_stall = m.valid && m.cu[7] && m.wreg != 0 && id_valid &&
                  (m.wreg == id_rs || (id_uses_rt && m.wreg == id_rt));
      asserts++;
      if (lu_stall !== exp_stall) begin
        fails++; mism++;
        if (mism < 10) $display("FAIL rand_stall[%0d]: got %b want %b", n, lu_stall, exp_stall);
      end
      if (flush_i) begin
        m.valid = 0; m.cu = 0; m.jal = 0;
        if (m.fcnt < cmax) m.fcnt++;
      end else if (hold_i) begin
        m.valid = m.valid;
      end else if (exp_stall) begin
        m.valid = 0; m.cu = 0; m.jal = 0;
        if (m.bcnt < cmax) m.bcnt++;
      end else begin
        m.valid = id_valid;
        m.cu = id_valid ? id_cu_out : 11'd0;
        m.jal = id_is_jal;
        m.pc4 = id_pc4; m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
        m.rs = id_rs; m.rt = id_rt; m.shamt = id_shamt;
        if (!id_valid || !id_cu_out[9]) m.wreg = 0;
        else if (id_is_jal) m.wreg = 31;
        else m.wreg = id_cu_out[10] ? id_rd : id_rt;
      end
      tick();
      asserts++;
      if (ex_valid !== m.valid || ex_cu_out !== m.cu || ex_is_jal !== m.jal ||
          int'(bubble_cnt) != m.bcnt || int'(flush_cnt) != m.fcnt ||
          (m.valid && ({ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, ex_shamt} !==
                       {m.pc4, m.rsd, m.rtd, m.imm, m.rs, m.rt, m.wreg, m.shamt}))) begin
        fails++; mism++;
        if (mism < 10)
          $display("FAIL rand_ex[%0d]: got v=%b cu=%h jal=%b wreg=%0d b=%0d f=%0d want v=%b cu=%h jal=%b wreg=%0d b=%0d f=%0d",
                   n, ex_valid, ex_cu_out, ex_is_jal, ex_wreg, bubble_cnt, flush_cnt,
                   m.valid, m.cu, m.jal, m.wreg, m.bcnt, m.fcnt);
      end
    end
    hold_i = 0; flush_i = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    hold_i = 0; flush_i = 0;
    drive(1'b0, 11'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_load_use();
    test_rs_only();
    test_flush_hold();
    test_dest();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
